instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Encodes instruction-field requests into 32-bit RV64 instruction words. It is the inverse of the decode stage. It feeds the fetch-side instruction memory loader and the self-test stimulus path. A valid/ready request is packed into a format-correct word, its immediate is range-checked, and the `LI` pseudo-op is expanded into one or two real instructions. Output words are delivered on a valid/ready stream.

Parameters:
INSTR_W, 32, output instruction width
REG_W, 5, register index width
IMM_W, 64, request immediate width

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  block can accept request
req_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J 6=SHIFT 7=LI
req_opcode  in  7  opcode (ignored for LI)
req_funct3  in  3  funct3
req_funct7  in  7  funct7 (R); bits[6:1] are funct6 for SHIFT
req_rd  in  REG_W  destination register
req_rs1  in  REG_W  source 1
req_rs2  in  REG_W  source 2
req_imm  in  IMM_W  signed immediate / byte offset
out_valid  out  1  output word valid
out_ready  in  1  consumer accepts word
out_instr  out  INSTR_W  encoded instruction
out_last  out  1  final word of this request
out_err  out  1  request rejected (range/alignment)

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-low on `reset_n`.
- Reset values: `out_valid`=0, `out_instr`=0, `out_last`=0, `out_err`=0, state=IDLE. `req_ready`=1 in the first cycle after reset deasserts.
- Handshakes:
  - A request is accepted when `req_valid` & `req_ready`.
  - An output word is transferred when `out_valid` & `out_ready`.
  - `out_*` hold stable while `out_valid`=1 and `out_ready`=0.
- Latency: the first word is registered, so `out_valid` rises the cycle after acceptance.
- States:
  - IDLE: no word held.
  - HOLD: single or final word held.
  - HOLD1: first of two `LI` words held; the second is staged internally.
- `req_ready` = (state==IDLE) | (state==HOLD & `out_ready`). This gives throughput of 1 word/cycle for single-word requests.
- Transitions:
  - IDLE or HOLD-consumed, plus accept: go to HOLD, or HOLD1 if `LI` needs two words.
  - HOLD-consumed with no accept: go to IDLE.
  - HOLD1-consumed: load the staged word and go to HOLD. `req_ready`=0 throughout HOLD1.
- Field packing (standard RV layouts):
  - R: funct7|rs2|rs1|f3|rd|op
  - I: imm[11:0]|rs1|f3|rd|op
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  - U: imm[31:12]|rd|op
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
  - SHIFT: funct6|shamt[5:0]|rs1|f3|rd|op
- Range checks:
  - I/S: −2048..2047.
  - B: −4096..4094, bit0=0.
  - J: ±1 MiB, bit0=0.
  - U: imm[11:0]=0 and imm within signed 32-bit.
  - SHIFT: 0..63.
  - LI: within signed 32-bit.
- Violation: emit a single word with `out_instr`=0, `out_err`=1, `out_last`=1.
- LI expansion:
  - If imm fits 12 bits: emit ADDI rd,x0,imm (1 word).
  - Otherwise: hi = (imm+0x800)>>12 (20 bits), lo = imm − (hi<<12).
    - Emit LUI rd,hi.
    - Then emit ADDIW rd,rd,lo, only if lo≠0.
  - ADDIW (not ADDI) is required so that hi=0x80000 is correct.
- `out_last`: 1 on every word except the first of a two-word LI.
- `req_rd`=x0 is encoded normally, with no suppression.
- Reset mid-operation: `reset_n`=0 in any state discards held and staged words in the same cycle edge.

Optional Feature:
- Macro: `ENCODER_RANGE_CHECK_EN`.
- Defined: the range checks above are active and `out_err` is driven.
- Undefined: no checks. Immediates are truncated to their field bits, `out_err` is tied to 0, and LI always expands to LUI+ADDIW via the hi/lo split even when imm fits 12 bits, except that lo=0 still skips ADDIW.

Test Plan:
- fmt=I, op=0x13, f3=0, rd=5, rs1=6, imm=−1, `out_ready`=1 → next cycle `out_instr`=0xFFF30293, `out_last`=1, `out_err`=0.
- fmt=LI, rd=1, imm=0x12345678 → 0x123450B7 (`out_last`=0), then 0x6780809B (`out_last`=1). `req_ready`=0 between the two words.
- fmt=LI, rd=1, imm=0x7FFFFFFF → 0x800000B7 then 0xFFF0809B. fmt=LI, imm=100 → single word 0x06400093.
- fmt=B, imm=3 (odd) → `out_instr`=0, `out_err`=1, `out_last`=1. fmt=I, imm=2048 → same error response.
- LI 0x12345678 with `out_ready`=0 for 3 cycles → 0x123450B7 is held stable and `req_ready` stays 0. After release the two words appear in order with no loss.
- Assert `reset_n`=0 while in HOLD1 → next cycle `out_valid`=0 and `req_ready`=1 after release, and the staged word is never emitted.

Source files
------------

// File: rtl/instr_encoder_if.sv
// instr_encoder_if
//   Request and output streams of the RV64 instruction encoder.
//   master : request producer / word consumer (drives req_*, out_ready)
//   slave  : the encoder (drives req_ready, out_valid, out_instr, out_last, out_err)
interface instr_encoder_if #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned IMM_W   = 64
);
    logic               req_valid;
    logic               req_ready;
    logic [2:0]         req_fmt;
    logic [6:0]         req_opcode;
    logic [2:0]         req_funct3;
    logic [6:0]         req_funct7;
    logic [REG_W-1:0]   req_rd;
    logic [REG_W-1:0]   req_rs1;
    logic [REG_W-1:0]   req_rs2;
    logic [IMM_W-1:0]   req_imm;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic               out_last;
    logic               out_err;

    modport master (
        output req_valid, req_fmt, req_opcode, req_funct3, req_funct7,
        output req_rd, req_rs1, req_rs2, req_imm, out_ready,
        input  req_ready, out_valid, out_instr, out_last, out_err
    );

    modport slave (
        input  req_valid, req_fmt, req_opcode, req_funct3, req_funct7,
        input  req_rd, req_rs1, req_rs2, req_imm, out_ready,
        output req_ready, out_valid, out_instr, out_last, out_err
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs instruction-field requests into 32-bit RV64 words. Formats R/I/S/B/U/J/SHIFT are
//   packed directly; the LI pseudo-op expands to ADDI, or LUI (+ ADDIW when the low part is
//   non-zero). The first word is registered; a second LI word is staged internally.
// Ports
//   clk     : clock
//   reset_n : synchronous active-low reset
//   bus     : instr_encoder_if.slave (req_* valid/ready request in, out_* valid/ready words out)
// Build option
//   ENCODER_RANGE_CHECK_EN : when defined, immediates are range-checked and rejected requests
//   yield a single zero word with out_err=1; LI uses ADDI when the immediate fits 12 bits.
//   When undefined, immediates are truncated, out_err stays 0 and LI always uses the hi/lo split.
module instr_encoder #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned IMM_W   = 64
) (
    input logic            clk,
    input logic            reset_n,
    instr_encoder_if.slave bus
);
    localparam logic [2:0] FmtR     = 3'd0;
    localparam logic [2:0] FmtI     = 3'd1;
    localparam logic [2:0] FmtS     = 3'd2;
    localparam logic [2:0] FmtB     = 3'd3;
    localparam logic [2:0] FmtU     = 3'd4;
    localparam logic [2:0] FmtJ     = 3'd5;
    localparam logic [2:0] FmtShift = 3'd6;
    localparam logic [2:0] FmtLi    = 3'd7;

    localparam logic [6:0] OpOpImm   = 7'h13;
    localparam logic [6:0] OpLui     = 7'h37;
    localparam logic [6:0] OpOpImm32 = 7'h1B;

    typedef enum logic [1:0] {StIdle, StHold, StHold1} state_e;

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [INSTR_W-1:0] staged_q, staged_d;
    logic               out_last_q, out_last_d;
    logic               out_err_q, out_err_d;

    logic [IMM_W-1:0]   imm;
    logic [4:0]         rd, rs1, rs2;
    logic [6:0]         op;
    logic [2:0]         f3;
    logic [31:0]        li_sum, li_lui, li_addiw, li_addi;
    logic               li_lo_nz;
    logic [31:0]        enc_word0, enc_word1;
    logic               enc_two, enc_err;
    logic               accept;

    // True when v is representable as a signed value of the given bit count.
    function automatic logic fits_signed(input logic [IMM_W-1:0] v, input int unsigned bits);
        logic [IMM_W-1:0] t;
        t = $signed(v) >>> (bits - 1);
        return (t == '0) || (t == '1);
    endfunction

    assign imm = bus.req_imm;
    assign rd  = bus.req_rd[4:0];
    assign rs1 = bus.req_rs1[4:0];
    assign rs2 = bus.req_rs2[4:0];
    assign op  = bus.req_opcode;
    assign f3  = bus.req_funct3;

    // Rounding the upper part by +0x800 keeps the sign-extended low 12 bits correct for ADDIW.
    assign li_sum   = imm[31:0] + 32'h0000_0800;
    assign li_lui   = {li_sum[31:12], rd, OpLui};
    assign li_addiw = {imm[11:0], rd, 3'b000, rd, OpOpImm32};
    assign li_addi  = {imm[11:0], 5'd0, 3'b000, rd, OpOpImm};
    assign li_lo_nz = (imm[11:0] != 12'd0);

    always_comb begin
        enc_word0 = '0;
        enc_word1 = '0;
        enc_two   = 1'b0;
        enc_err   = 1'b0;
        case (bus.req_fmt)
            FmtR:     enc_word0 = {bus.req_funct7, rs2, rs1, f3, rd, op};
            FmtI:     enc_word0 = {imm[11:0], rs1, f3, rd, op};
            FmtS:     enc_word0 = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FmtB:     enc_word0 = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FmtU:     enc_word0 = {imm[31:12], rd, op};
            FmtJ:     enc_word0 = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            FmtShift: enc_word0 = {bus.req_funct7[6:1], imm[5:0], rs1, f3, rd, op};
            FmtLi: begin
`ifdef ENCODER_RANGE_CHECK_EN
                if (fits_signed(imm, 12)) begin
                    enc_word0 = li_addi;
                end else begin
                    enc_word0 = li_lui;
                    enc_word1 = li_addiw;
                    enc_two   = li_lo_nz;
                end
`else
                enc_word0 = li_lui;
                enc_word1 = li_addiw;
                enc_two   = li_lo_nz;
`endif
            end
            default: ;
        endcase
`ifdef ENCODER_RANGE_CHECK_EN
        case (bus.req_fmt)
            FmtI, FmtS: enc_err = !fits_signed(imm, 12);
            FmtB:       enc_err = !fits_signed(imm, 13) || imm[0];
            FmtJ:       enc_err = !fits_signed(imm, 21) || imm[0];
            FmtU:       enc_err = (imm[11:0] != 12'd0) || !fits_signed(imm, 32);
            FmtShift:   enc_err = (imm[IMM_W-1:6] != '0);
            FmtLi:      enc_err = !fits_signed(imm, 32);
            default:    enc_err = 1'b0;
        endcase
        if (enc_err) begin
            enc_word0 = '0;
            enc_word1 = '0;
            enc_two   = 1'b0;
        end
`endif
    end

    // Upper immediate bits only matter to the range checks.
    logic unused_bits;
    assign unused_bits = ^{imm[IMM_W-1:32], li_sum[11:0]};

    assign bus.req_ready = (state_q == StIdle) || ((state_q == StHold) && bus.out_ready);
    assign bus.out_valid = (state_q != StIdle);
    assign bus.out_instr = out_instr_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_err   = out_err_q;

    always_comb begin
        state_d     = state_q;
        out_instr_d = out_instr_q;
        out_last_d  = out_last_q;
        out_err_d   = out_err_q;
        staged_d    = staged_q;
        accept      = 1'b0;
        case (state_q)
            StIdle: accept = bus.req_valid;
            StHold: begin
                if (bus.out_ready) begin
                    if (bus.req_valid) begin
                        accept = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StHold1: begin
                if (bus.out_ready) begin
                    out_instr_d = staged_q;
                    out_last_d  = 1'b1;
                    out_err_d   = 1'b0;
                    state_d     = StHold;
                end
            end
            default: state_d = StIdle;
        endcase
        if (accept) begin
            out_instr_d = enc_word0;
            out_last_d  = !enc_two;
            out_err_d   = enc_err;
            staged_d    = enc_word1;
            state_d     = enc_two ? StHold1 : StHold;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            out_instr_q <= '0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
            staged_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_instr_q <= out_instr_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
            staged_q    <= staged_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
//   Randomized and directed stimulus for instr_encoder; expected words come from a reference
//   model written with integer arithmetic and are queued on acceptance, then compared by an
//   independent monitor whenever the encoder presents a word.
module tb_instr_encoder;
    localparam int FMT_R = 0, FMT_I = 1, FMT_S = 2, FMT_B = 3;
    localparam int FMT_U = 4, FMT_J = 5, FMT_SHIFT = 6, FMT_LI = 7;

    typedef struct packed {
        logic [31:0] instr;
        logic        last;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   rand_ready = 1'b0;
    exp_t exp_q[$];
    exp_t const_q[$];

    always #5 clk = ~clk;

    instr_encoder_if #(.INSTR_W(32), .REG_W(5), .IMM_W(64)) bus ();

    instr_encoder #(.INSTR_W(32), .REG_W(5), .IMM_W(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint unsigned fld(input longint v, input int hi, input int lo);
        longint unsigned u;
        longint unsigned m;
        u = v;
        m = (64'd1 << (hi - lo + 1)) - 64'd1;
        return (u >> lo) & m;
    endfunction

    function automatic bit in_range(input longint v, input longint lo, input longint hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic void pushw(input longint unsigned w, input bit last, input bit err);
        exp_t e;
        e.instr = w[31:0];
        e.last  = last;
        e.err   = err;
        exp_q.push_back(e);
    endfunction

    function automatic void pushc(input logic [31:0] w, input bit last, input bit err);
        exp_t e;
        e.instr = w;
        e.last  = last;
        e.err   = err;
        const_q.push_back(e);
    endfunction

    // Reference model: one or two expected words per request.
    function automatic void model_push(input int fmt, input int op, input int f3, input int f7,
                                       input int rd, input int rs1, input int rs2,
                                       input longint imm);
        longint unsigned uop, uf3, uf7, urd, urs1, urs2, w;
        longint          hi, lo;
        bit              ok;
        bit              li_short;
        uop  = op;
        uf3  = f3;
        uf7  = f7;
        urd  = rd;
        urs1 = rs1;
        urs2 = rs2;
        ok   = 1'b1;
        li_short = 1'b0;
`ifdef ENCODER_RANGE_CHECK_EN
        case (fmt)
            FMT_I, FMT_S: ok = in_range(imm, -2048, 2047);
            FMT_B:        ok = in_range(imm, -4096, 4094) && ((imm & 1) == 0);
            FMT_J:        ok = in_range(imm, -1048576, 1048574) && ((imm & 1) == 0);
            FMT_U:        ok = ((imm & 'hFFF) == 0) && in_range(imm, -(64'sd1 << 31),
                                                                (64'sd1 << 31) - 1);
            FMT_SHIFT:    ok = in_range(imm, 0, 63);
            FMT_LI:       ok = in_range(imm, -(64'sd1 << 31), (64'sd1 << 31) - 1);
            default:      ok = 1'b1;
        endcase
        li_short = in_range(imm, -2048, 2047);
`endif
        if (!ok) begin
            pushw(0, 1'b1, 1'b1);
            return;
        end
        w = 0;
        case (fmt)
            FMT_R: w = (uf7 << 25) | (urs2 << 20) | (urs1 << 15) | (uf3 << 12) | (urd << 7) | uop;
            FMT_I: w = (fld(imm, 11, 0) << 20) | (urs1 << 15) | (uf3 << 12) | (urd << 7) | uop;
            FMT_S: w = (fld(imm, 11, 5) << 25) | (urs2 << 20) | (urs1 << 15) | (uf3 << 12)
                     | (fld(imm, 4, 0) << 7) | uop;
            FMT_B: w = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | (urs2 << 20)
                     | (urs1 << 15) | (uf3 << 12) | (fld(imm, 4, 1) << 8)
                     | (fld(imm, 11, 11) << 7) | uop;
            FMT_U: w = (fld(imm, 31, 12) << 12) | (urd << 7) | uop;
            FMT_J: w = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21)
                     | (fld(imm, 11, 11) << 20) | (fld(imm, 19, 12) << 12) | (urd << 7) | uop;
            FMT_SHIFT: w = ((uf7 >> 1) << 26) | (fld(imm, 5, 0) << 20) | (urs1 << 15)
                         | (uf3 << 12) | (urd << 7) | uop;
            default: w = 0;
        endcase
        if (fmt != FMT_LI) begin
            pushw(w, 1'b1, 1'b0);
        end else if (li_short) begin
            pushw((fld(imm, 11, 0) << 20) | (urd << 7) | 'h13, 1'b1, 1'b0);
        end else begin
            hi = (imm + 2048) >>> 12;
            lo = imm - hi * 4096;
            pushw((fld(hi, 19, 0) << 12) | (urd << 7) | 'h37, lo == 0, 1'b0);
            if (lo != 0) pushw((fld(lo, 11, 0) << 20) | (urd << 15) | (urd << 7) | 'h1B,
                               1'b1, 1'b0);
        end
    endfunction

    // Presents one request starting just after a rising edge; returns just after its
    // acceptance edge with req_valid dropped.
    task automatic send(input int fmt, input int op, input int f3, input int f7, input int rd,
                        input int rs1, input int rs2, input longint imm);
        int n;
        bus.req_fmt    = fmt[2:0];
        bus.req_opcode = op[6:0];
        bus.req_funct3 = f3[2:0];
        bus.req_funct7 = f7[6:0];
        bus.req_rd     = rd[4:0];
        bus.req_rs1    = rs1[4:0];
        bus.req_rs2    = rs2[4:0];
        bus.req_imm    = imm;
        bus.req_valid  = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            n++;
            if (n > 200) break;
        end
        if (n > 200) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: got req_ready=0 expected 1 within 200 cycles");
            const_q.delete();
        end else if (const_q.size() != 0) begin
            while (const_q.size() != 0) exp_q.push_back(const_q.pop_front());
        end else begin
            model_push(fmt, op, f3, f7, rd, rs1, rs2, imm);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || bus.out_valid) begin
            errors++;
            $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Random consumer back-pressure.
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: compare every presented word against the head of the scoreboard.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (mon_en) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%08h expected no word", bus.out_instr);
                end else begin
                    e = exp_q[0];
                    check("out_instr", 64'(bus.out_instr), 64'(e.instr));
                    check("out_last", 64'(bus.out_last), 64'(e.last));
                    check("out_err", 64'(bus.out_err), 64'(e.err));
                    check("req_ready_busy", 64'(bus.req_ready),
                          e.last ? 64'(bus.out_ready) : 64'd0);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end else begin
                check("req_ready_idle", 64'(bus.req_ready), 64'd1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        longint bnd [0:21] = '{-1, 0, 1, 3, 63, 64, 100, 2047, 2048, -2048, -2049, 4094,
                               4095, -4096, 1048574, -1048576, 1048576, 64'h7FFF_FFFF,
                               64'shFFFF_FFFF_8000_0000, 64'h8000_0000, 64'h1234_5678,
                               64'h1234_5000};
        longint imm;
        int     fmt;

        reset_n        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_fmt    = '0;
        bus.req_opcode = '0;
        bus.req_funct3 = '0;
        bus.req_funct7 = '0;
        bus.req_rd     = '0;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.req_imm    = '0;
        bus.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_instr", 64'(bus.out_instr), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        check("rst_out_err", 64'(bus.out_err), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Directed words with fixed expected encodings.
        bus.out_ready = 1'b1;
        pushc(32'hFFF3_0293, 1'b1, 1'b0);
        send(FMT_I, 'h13, 0, 0, 5, 6, 0, -1);
        pushc(32'h1234_50B7, 1'b0, 1'b0);
        pushc(32'h6780_809B, 1'b1, 1'b0);
        send(FMT_LI, 0, 0, 0, 1, 0, 0, 64'h1234_5678);
        pushc(32'h8000_00B7, 1'b0, 1'b0);
        pushc(32'hFFF0_809B, 1'b1, 1'b0);
        send(FMT_LI, 0, 0, 0, 1, 0, 0, 64'h7FFF_FFFF);
`ifdef ENCODER_RANGE_CHECK_EN
        pushc(32'h0640_0093, 1'b1, 1'b0);
        send(FMT_LI, 0, 0, 0, 1, 0, 0, 100);
        pushc(32'h0, 1'b1, 1'b1);
        send(FMT_B, 'h63, 0, 0, 0, 1, 2, 3);
        pushc(32'h0, 1'b1, 1'b1);
        send(FMT_I, 'h13, 0, 0, 5, 6, 0, 2048);
`else
        pushc(32'h0000_00B7, 1'b0, 1'b0);
        pushc(32'h0640_809B, 1'b1, 1'b0);
        send(FMT_LI, 0, 0, 0, 1, 0, 0, 100);
        send(FMT_B, 'h63, 0, 0, 0, 1, 2, 3);
        send(FMT_I, 'h13, 0, 0, 5, 6, 0, 2048);
`endif
        drain();

        // Stall the first LI word for three cycles.
        bus.out_ready = 1'b0;
        send(FMT_LI, 0, 0, 0, 1, 0, 0, 64'h1234_5678);
        repeat (3) @(posedge clk);
        #1;
        check("stall_req_ready", 64'(bus.req_ready), 64'd0);
        check("stall_held_word", 64'(bus.out_instr), 64'h1234_50B7);
        bus.out_ready = 1'b1;
        drain();

        // Reset while the second LI word is staged.
        bus.out_ready = 1'b0;
        send(FMT_LI, 0, 0, 0, 1, 0, 0, 64'h1234_5678);
        check("hold1_valid", 64'(bus.out_valid), 64'd1);
        mon_en  = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_instr", 64'(bus.out_instr), 64'd0);
        reset_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("rst_mid_req_ready", 64'(bus.req_ready), 64'd1);
        mon_en = 1'b1;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_mid_no_staged", 64'(bus.out_valid), 64'd0);

        // Randomized traffic with random back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            fmt = $urandom_range(0, 7);
            case ($urandom_range(0, 5))
                0: imm = bnd[$urandom_range(0, 21)];
                1: imm = longint'($urandom_range(0, 8191)) - 4096;
                2: imm = longint'($signed($urandom));
                3: imm = {$urandom, $urandom};
                4: imm = longint'($signed($urandom)) & -64'sd4096;
                default: imm = (longint'($urandom_range(0, 4095)) - 2048) * 2;
            endcase
            send(fmt, $urandom_range(0, 127), $urandom_range(0, 7), $urandom_range(0, 127),
                 $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
